// File: rtl/hierIncludeB_package.sv
// Shared types and constants for the hierIncludeB arbiters.
package hierIncludeB_package;

    localparam int BY_NUM_REQ   = 4;
    localparam int BY_BURST_MAX = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } by_arb_state_t;

    typedef logic [$clog2(BY_NUM_REQ)-1:0] by_src_id_t;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set bit of req at or above ptr, with wrap.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Scan N positions starting at ptr; first hit wins.
    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/by_req_arbiter.sv
// Round-robin burst arbiter feeding blockBY's x port through one output register.
module by_req_arbiter
    import hierIncludeB_package::*;
#(
    parameter int NUM_REQ   = BY_NUM_REQ,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = BY_BURST_MAX,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_vld,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_rdy,
    output logic                      out_vld,
    output logic [DATA_W-1:0]         out_data,
    output logic [ID_W-1:0]           out_id,
    input  logic                      out_rdy,
    output logic                      busy
);

    // The burst counter is 4 bits wide.
    if (BURST_MAX < 1 || BURST_MAX > 15) begin : g_burst_range
        $error("by_req_arbiter: BURST_MAX must be within 1..15");
    end

    by_arb_state_t   state, state_nx;
    logic [ID_W-1:0] g, g_nx, ptr, ptr_nx, pick, gnt;
    logic [3:0]      cnt, cnt_nx;
    logic            load, found, gnt_ok, xfer;

    // Successor index, wrapping for non-power-of-two requester counts.
    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] v);
        return (int'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
    endfunction

    rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
        .req   (req_vld),
        .ptr   (ptr),
        .found (found),
        .idx   (pick)
    );

    // Grant selection: held grant in GRANT, fresh pick in IDLE so switching costs no bubble.
    always_comb begin
        load    = !out_vld || out_rdy;
        gnt     = (state == GRANT) ? g : pick;
        gnt_ok  = (state == GRANT) || found;
        req_rdy = '0;
        if (!rst && load && gnt_ok) req_rdy[gnt] = req_vld[gnt];
        xfer    = |(req_vld & req_rdy);
    end

    // Next-state: pick/hold grant, count beats, release on burst limit or idle requester.
    always_comb begin
        state_nx = state;
        g_nx     = g;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    g_nx = pick;
                    if (xfer && BURST_MAX == 1) begin
                        ptr_nx = next_id(pick);
                        cnt_nx = '0;
                    end else begin
                        state_nx = GRANT;
                        cnt_nx   = xfer ? 4'd1 : 4'd0;
                    end
                end
            end
            GRANT: begin
                if (load) begin
                    if (!req_vld[g] || (xfer && int'(cnt) + 1 == BURST_MAX)) begin
                        state_nx = IDLE;
                        ptr_nx   = next_id(g);
                        cnt_nx   = '0;
                    end else if (xfer) begin
                        cnt_nx = cnt + 4'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Arbitration state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            g     <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            g     <= g_nx;
            ptr   <= ptr_nx;
            cnt   <= cnt_nx;
        end
    end

    // Output stage: load on transfer, hold under backpressure, clear when drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_id   <= '0;
        end else if (xfer) begin
            out_vld  <= 1'b1;
            out_data <= req_data[gnt*DATA_W +: DATA_W];
            out_id   <= gnt;
        end else if (out_rdy) begin
            out_vld  <= 1'b0;
        end
    end

    assign busy = (state == GRANT);

endmodule

// File: tb/tb_by_req_arbiter.sv
// Directed bench for by_req_arbiter with an in-order beat scoreboard.
module tb_by_req_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int BM = 4;
    localparam int IW = 2;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req_vld = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]    req_rdy;
    logic             out_vld;
    logic [DW-1:0]    out_data;
    logic [IW-1:0]    out_id;
    logic             out_rdy = 1'b1;
    logic             busy;

    by_req_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .BURST_MAX(BM)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_vld  (req_vld),
        .req_data (req_data),
        .req_rdy  (req_rdy),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_id   (out_id),
        .out_rdy  (out_rdy),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pops, first_pop, last_pop, rdy_cyc, vld_cyc;
    int remaining [NR];
    int seq [NR];
    logic [DW-1:0] base [NR];
    beat_t exp_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_vld[i] = remaining[i] > 0;
            req_data[i*DW +: DW] = base[i] + DW'(seq[i]);
        end
    endtask

    task automatic set_req(input int i, input int n, input logic [DW-1:0] b);
        remaining[i] = n;
        seq[i] = 0;
        base[i] = b;
        drive();
    endtask

    task automatic expect_beats(input int id, input logic [DW-1:0] b, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back('{id: IW'(id), data: b + DW'(k)});
    endtask

    task automatic clear_stats();
        pops = 0; first_pop = -1; last_pop = -1; rdy_cyc = -1; vld_cyc = -1;
    endtask

    // One clock: sample at negedge (scoreboard, handshakes), then advance requesters.
    task automatic step();
        logic [NR-1:0] hs;
        beat_t e;
        @(negedge clk);
        cyc++;
        hs = req_vld & req_rdy;
        if (|req_rdy && rdy_cyc < 0) rdy_cyc = cyc;
        if (out_vld && vld_cyc < 0) vld_cyc = cyc;
        if (!rst && out_vld && out_rdy) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", 64'(out_data), 64'(e.data));
                chk("out_id", 64'(out_id), 64'(e.id));
                pops++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) if (hs[i]) begin
            seq[i]++;
            remaining[i]--;
        end
        drive();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < NR; i++) set_req(i, 0, '0);
        repeat (n) step();
        exp_q.delete();
        rst = 1'b0;
        clear_stats();
    endtask

    task automatic drain(input string tag, input int maxc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            step();
            n++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
        repeat (3) step();
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            remaining[i] = 0; seq[i] = 0; base[i] = '0;
        end
        clear_stats();

        // Reset values
        rst = 1'b1;
        repeat (3) step();
        chk("rst_out_vld", 64'(out_vld), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_id", 64'(out_id), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_rdy", 64'(req_rdy), 64'd0);
        rst = 1'b0;
        clear_stats();

        // Single requester: 6 beats across a forced rotation
        out_rdy = 1'b1;
        set_req(0, 6, 32'hA0);
        expect_beats(0, 32'hA0, 6);
        drain("single_drain", 40);
        chk("single_pops", 64'(pops), 64'd6);
        chk("single_latency", 64'(vld_cyc - rdy_cyc), 64'd1);
        chk("single_idle_busy", 64'(busy), 64'd0);

        // Fair rotation with every requester pending
        do_reset(2);
        set_req(0, 8, 32'h100);
        set_req(1, 4, 32'h110);
        set_req(2, 4, 32'h120);
        set_req(3, 4, 32'h130);
        expect_beats(0, 32'h100, 4);
        expect_beats(1, 32'h110, 4);
        expect_beats(2, 32'h120, 4);
        expect_beats(3, 32'h130, 4);
        expect_beats(0, 32'h104, 4);
        drain("fair_drain", 60);
        chk("fair_pops", 64'(pops), 64'd20);
        chk("fair_gapless", 64'(last_pop - first_pop), 64'd19);

        // Backpressure: output held, no ready upstream
        do_reset(2);
        out_rdy = 1'b0;
        set_req(1, 2, 32'h55);
        expect_beats(1, 32'h55, 2);
        step();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_out_vld", 64'(out_vld), 64'd1);
            chk("bp_out_data", 64'(out_data), 64'h55);
            chk("bp_req_rdy", 64'(req_rdy), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
        end
        out_rdy = 1'b1;
        step();
        chk("bp_resume_vld", 64'(out_vld), 64'd1);
        chk("bp_resume_data", 64'(out_data), 64'h56);
        drain("bp_drain", 20);

        // Simultaneous drain and load
        do_reset(2);
        set_req(2, 2, 32'h77);
        expect_beats(2, 32'h77, 2);
        step();
        chk("dl_first_vld", 64'(out_vld), 64'd1);
        chk("dl_first_data", 64'(out_data), 64'h77);
        step();
        chk("dl_second_vld", 64'(out_vld), 64'd1);
        chk("dl_second_data", 64'(out_data), 64'h78);
        drain("dl_drain", 20);

        // Early release: requester 2 goes idle after 2 beats
        do_reset(2);
        set_req(2, 2, 32'h20);
        set_req(3, 3, 32'h30);
        expect_beats(2, 32'h20, 2);
        expect_beats(3, 32'h30, 3);
        drain("early_drain", 30);
        chk("early_pops", 64'(pops), 64'd5);

        // Reset mid-burst during requester 1's third beat
        do_reset(2);
        set_req(0, 4, 32'h300);
        set_req(1, 8, 32'h310);
        set_req(3, 8, 32'h330);
        expect_beats(0, 32'h300, 4);
        expect_beats(1, 32'h310, 2);
        for (int n = 0; n < 20 && seq[1] < 2; n++) step();
        chk("mid_seq_reached", 64'(seq[1]), 64'd2);
        chk("mid_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        chk("mid_rst_out_vld", 64'(out_vld), 64'd0);
        chk("mid_rst_out_data", 64'(out_data), 64'd0);
        chk("mid_rst_out_id", 64'(out_id), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_req_rdy", 64'(req_rdy), 64'd0);
        exp_q.delete();
        clear_stats();
        set_req(1, 0, 32'h0);
        set_req(0, 2, 32'h3A0);
        set_req(3, 3, 32'h3B0);
        expect_beats(0, 32'h3A0, 2);
        expect_beats(3, 32'h3B0, 3);
        rst = 1'b0;
        drain("mid_post_drain", 30);
        chk("mid_post_pops", 64'(pops), 64'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
